ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte (reset 0xFF, set-LEDs 0xED, enable 0xF4, …) from the CPU/IO side to the keyboard over the shared ARDUINO_IO PS/2 clock/data pins. It is the outbound counterpart of the keyboard receive path that feeds ps2_data/ps2_data_en. It drives the lines open-drain through output-enables and asserts tx_active so the receive path ignores traffic during a transmission.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_line_sync.sv | 32 +++
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and command bytes for the PS/2 host transmit and receive paths.
package ps2_pkg;
   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      DATA,
      ACK,
      WAIT_IDLE,
      DONE,
      ERROR
   } ps2_state_t;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;
endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins with clock falling-edge detect.
// A pin falling edge shows up on clk_fall two cycles later and is acted on at the third edge.
module ps2_line_sync (
   input  logic clk50,
   input  logic rst,
   input  logic clk_pin,
   input  logic dat_pin,
   output logic clk_lvl,
   output logic dat_lvl,
   output logic clk_fall
);
   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_prev;

   // Idle PS/2 lines float high, so reset to 1 to avoid a false edge out of reset.
   always_ff @(posedge clk50) begin
      if (rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], clk_pin};
         dat_sync <= {dat_sync[0], dat_pin};
         clk_prev <= clk_sync[1];
      end
   end

   assign clk_lvl  = clk_sync[1];
   assign dat_lvl  = dat_sync[1];
   assign clk_fall = clk_prev & ~clk_sync[1];
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Lines are driven open-drain via output enables; all outputs are registered.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_START  = 750000,
   parameter int TIMEOUT_FRAME  = 100000
) (
   input  logic       clk50,
   input  logic       rst,
   input  logic [7:0] cmd_data,
   input  logic       cmd_send,
   output logic       ready,
   output logic       tx_active,
   output logic       done,
   output logic       err_timeout,
   output logic       err_noack,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int MAXP_A = (INHIBIT_CYCLES > TIMEOUT_START) ? INHIBIT_CYCLES : TIMEOUT_START;
   localparam int MAXP   = (MAXP_A > TIMEOUT_FRAME) ? MAXP_A : TIMEOUT_FRAME;
   localparam int CW     = $clog2(MAXP + 1);

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(TIMEOUT_START - 1);
   localparam logic [CW-1:0] FRAME_LAST = CW'(TIMEOUT_FRAME - 1);

   ps2_state_t    state;
   logic [CW-1:0] tmr;
   logic [CW-1:0] tmr_inc;
   logic [3:0]    edge_cnt;
   logic [3:0]    edge_nxt;
   logic [7:0]    shift;
   logic          parity;
   logic          rts_rel;
   logic          clk_lvl;
   logic          dat_lvl;
   logic          clk_fall;

   ps2_line_sync u_sync (
      .clk50    (clk50),
      .rst      (rst),
      .clk_pin  (ps2_clk_in),
      .dat_pin  (ps2_dat_in),
      .clk_lvl  (clk_lvl),
      .dat_lvl  (dat_lvl),
      .clk_fall (clk_fall)
   );

   assign tmr_inc  = (tmr == '1) ? tmr : tmr + CW'(1);
   assign edge_nxt = (edge_cnt == 4'hF) ? edge_cnt : edge_cnt + 4'd1;

   always_ff @(posedge clk50) begin
      if (rst) begin
         state       <= IDLE;
         tmr         <= '0;
         edge_cnt    <= '0;
         shift       <= '0;
         parity      <= 1'b0;
         rts_rel     <= 1'b0;
         ready       <= 1'b1;
         tx_active   <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         err_noack   <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_dat_oe  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_send && ready) begin
                  shift       <= cmd_data;
                  parity      <= ~^cmd_data;
                  err_timeout <= 1'b0;
                  err_noack   <= 1'b0;
                  ready       <= 1'b0;
                  tx_active   <= 1'b1;
                  ps2_clk_oe  <= 1'b1;
                  ps2_dat_oe  <= 1'b0;
                  tmr         <= '0;
                  edge_cnt    <= '0;
                  state       <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (tmr == INH_LAST) begin
                  ps2_dat_oe <= 1'b1;
                  rts_rel    <= 1'b0;
                  tmr        <= '0;
                  state      <= RTS;
               end else begin
                  tmr <= tmr_inc;
               end
            end
            RTS: begin
               if (!rts_rel) begin
                  ps2_clk_oe <= 1'b0;
                  rts_rel    <= 1'b1;
                  tmr        <= '0;
               end else if (clk_fall) begin
                  ps2_dat_oe <= ~shift[0];
                  shift      <= shift >> 1;
                  edge_cnt   <= 4'd1;
                  tmr        <= '0;
                  state      <= DATA;
               end else if (tmr == START_LAST) begin
                  ps2_dat_oe  <= 1'b0;
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= ERROR;
               end else begin
                  tmr <= tmr_inc;
               end
            end
            DATA, ACK: begin
               // Edge wins over a timer expiry landing in the same cycle.
               if (clk_fall) begin
                  edge_cnt <= edge_nxt;
                  tmr      <= tmr_inc;
                  if (edge_nxt <= 4'd8) begin
                     ps2_dat_oe <= ~shift[0];
                     shift      <= shift >> 1;
                  end else if (edge_nxt == 4'd9) begin
                     ps2_dat_oe <= ~parity;
                  end else if (edge_nxt == 4'd10) begin
                     ps2_dat_oe <= 1'b0;
                     state      <= ACK;
                  end else if (!dat_lvl) begin
                     tmr   <= '0;
                     state <= WAIT_IDLE;
                  end else begin
                     err_noack <= 1'b1;
                     done      <= 1'b1;
                     state     <= ERROR;
                  end
               end else if (tmr == FRAME_LAST) begin
                  ps2_dat_oe  <= 1'b0;
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= ERROR;
               end else begin
                  tmr <= tmr_inc;
               end
            end
            WAIT_IDLE: begin
               if (clk_lvl && dat_lvl) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (tmr == FRAME_LAST) begin
                  err_timeout <= 1'b1;
                  done        <= 1'b1;
                  state       <= ERROR;
               end else begin
                  tmr <= tmr_inc;
               end
            end
            DONE, ERROR: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               ready      <= 1'b1;
               tx_active  <= 1'b0;
               tmr        <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
